// File: rtl/sdc_strobe_counter_if.sv
// rtl/sdc_strobe_counter_if.sv - strobe counter handshake bundle (clr present with SDC_CNTR_CLR_EN)
interface sdc_strobe_counter_if #(
  parameter int dw = 8
);
  logic          enable;
  logic          start_strb;
  logic [dw-1:0] cntr;
  logic          strb;
`ifdef SDC_CNTR_CLR_EN
  logic          clr;

  modport master (output enable, start_strb, clr, input cntr, strb);
  modport slave  (input enable, start_strb, clr, output cntr, strb);
`else
  modport master (output enable, start_strb, input cntr, strb);
  modport slave  (input enable, start_strb, output cntr, strb);
`endif
endinterface

// File: rtl/sdc_strobe_counter.sv
// rtl/sdc_strobe_counter.sv - event/sequence strobe counter for the SD read path; optional clr via SDC_CNTR_CLR_EN
module sdc_strobe_counter #(
  parameter int          dw  = 8,
  parameter int unsigned max = 'h40,
  parameter bit          SEQ = 1'b0
) (
  input logic                clk,
  input logic                reset,
  sdc_strobe_counter_if.slave bus
);

  localparam logic [dw-1:0] max_c  = dw'(max);
  localparam logic [dw-1:0] last_c = dw'(max - 1);
  localparam logic [dw-1:0] one_c  = dw'(1);

  typedef enum logic {idle, run} state_t;

  state_t        state;
  logic [dw-1:0] cntr_q;
  logic          strb_q;
  logic          clr_in;

`ifdef SDC_CNTR_CLR_EN
  assign clr_in = bus.clr;
`else
  assign clr_in = 1'b0;
`endif

  assign bus.cntr = cntr_q;
  assign bus.strb = strb_q;

  // Single state/counter register; SEQ selects modulo event counting or start-launched runs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= idle;
      cntr_q <= '0;
      strb_q <= 1'b0;
    end else if (clr_in) begin
      // clr aborts everything, including a strobe that would fire on this edge
      state  <= idle;
      cntr_q <= '0;
      strb_q <= 1'b0;
    end else if (!SEQ) begin
      state <= idle;
      if (bus.enable) begin
        if (cntr_q == last_c) begin
          cntr_q <= '0;
          strb_q <= 1'b1;
        end else begin
          cntr_q <= cntr_q + one_c;
          strb_q <= 1'b0;
        end
      end else begin
        strb_q <= 1'b0;
      end
    end else begin
      strb_q <= 1'b0;
      case (state)
        idle: begin
          if (bus.start_strb) begin
            // The start edge is the first bit of the run, hence the load of 1
            state  <= run;
            cntr_q <= one_c;
          end else begin
            cntr_q <= '0;
          end
        end
        run: begin
          // A finishing run still strobes even when a restart lands on the same edge
          if (bus.enable && cntr_q == max_c) begin
            strb_q <= 1'b1;
          end
          if (bus.start_strb) begin
            cntr_q <= one_c;
          end else if (bus.enable) begin
            if (cntr_q == max_c) begin
              cntr_q <= '0;
              state  <= idle;
            end else begin
              cntr_q <= cntr_q + one_c;
            end
          end
        end
        default: begin
          state  <= idle;
          cntr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_strobe_counter.sv
// tb/tb_sdc_strobe_counter.sv - self-checking bench for sdc_strobe_counter in event and sequence modes
module tb_sdc_strobe_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sdc_strobe_counter_if #(.dw(8)) bus_e ();
  sdc_strobe_counter_if #(.dw(5)) bus_a ();
  sdc_strobe_counter_if #(.dw(8)) bus_b ();

  sdc_strobe_counter #(.dw(8), .max(8'h40), .SEQ(1'b0)) dut_e (.clk(clk), .reset(reset), .bus(bus_e));
  sdc_strobe_counter #(.dw(5), .max(5'h10), .SEQ(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  sdc_strobe_counter #(.dw(8), .max(8'h40), .SEQ(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_e.enable = 1'b0; bus_e.start_strb = 1'b0;
    bus_a.enable = 1'b0; bus_a.start_strb = 1'b0;
    bus_b.enable = 1'b0; bus_b.start_strb = 1'b0;
`ifdef SDC_CNTR_CLR_EN
    bus_e.clr = 1'b0; bus_a.clr = 1'b0; bus_b.clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Launch a 64-bit run on bus_b and advance until its counter reads target
  task automatic run_b_to(input int target);
    int guard;
    bus_b.enable = 1'b1;
    bus_b.start_strb = 1'b1;
    tick();
    bus_b.start_strb = 1'b0;
    guard = 0;
    while (int'(bus_b.cntr) != target && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL run_b_to_timeout: cntr=%0d never reached %0d", bus_b.cntr, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_e.enable = 1'($urandom_range(0, 1)); bus_e.start_strb = 1'($urandom_range(0, 1));
      bus_a.enable = 1'($urandom_range(0, 1)); bus_a.start_strb = 1'($urandom_range(0, 1));
      bus_b.enable = 1'($urandom_range(0, 1)); bus_b.start_strb = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (bus_e.cntr !== 8'd0 || bus_e.strb !== 1'b0) begin
        errors++; $display("FAIL reset_event: cntr=%0d strb=%0b required 0/0", bus_e.cntr, bus_e.strb);
      end
      checks++;
      if (bus_a.cntr !== 5'd0 || bus_a.strb !== 1'b0) begin
        errors++; $display("FAIL reset_seq16: cntr=%0d strb=%0b required 0/0", bus_a.cntr, bus_a.strb);
      end
      checks++;
      if (bus_b.cntr !== 8'd0 || bus_b.strb !== 1'b0) begin
        errors++; $display("FAIL reset_seq64: cntr=%0d strb=%0b required 0/0", bus_b.cntr, bus_b.strb);
      end
    end
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus_e.cntr !== 8'd0 || bus_a.cntr !== 5'd0 || bus_b.cntr !== 8'd0 ||
          bus_e.strb !== 1'b0 || bus_a.strb !== 1'b0 || bus_b.strb !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: cntr e/a/b=%0d/%0d/%0d strb=%0b%0b%0b required all 0",
                 bus_e.cntr, bus_a.cntr, bus_b.cntr, bus_e.strb, bus_a.strb, bus_b.strb);
      end
    end
  endtask

  task automatic test_event_wrap();
    int n;
    int gap;
    int strobe_at[$];
    do_reset();
    n = 0;
    while (n < 130) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus_e.enable = 1'b0;
        bus_e.start_strb = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if (int'(bus_e.cntr) !== n % 64 || bus_e.strb !== 1'b0) begin
          errors++;
          $display("FAIL event_hold: cntr=%0d strb=%0b required %0d/0", bus_e.cntr, bus_e.strb, n % 64);
        end
      end
      bus_e.enable = 1'b1;
      bus_e.start_strb = 1'($urandom_range(0, 1));
      tick();
      n++;
      checks++;
      if (int'(bus_e.cntr) !== n % 64 || bus_e.strb !== (n % 64 == 0)) begin
        errors++;
        $display("FAIL event_count: enable#%0d cntr=%0d strb=%0b required %0d/%0b",
                 n, bus_e.cntr, bus_e.strb, n % 64, (n % 64 == 0));
      end
      if (bus_e.strb === 1'b1) strobe_at.push_back(n);
    end
    bus_e.enable = 1'b0;
    tick();
    checks++;
    if (bus_e.cntr !== 8'd2 || bus_e.strb !== 1'b0) begin
      errors++; $display("FAIL event_final: cntr=%0d strb=%0b required 2/0", bus_e.cntr, bus_e.strb);
    end
    checks++;
    if (strobe_at.size() != 2 || strobe_at[0] != 64 || strobe_at[1] != 128) begin
      errors++; $display("FAIL event_strobe_positions: count=%0d required 2 at enables 64 and 128", strobe_at.size());
    end
  endtask

  task automatic test_seq_length();
    int strobes;
    do_reset();
    bus_a.enable = 1'b1;
    bus_a.start_strb = 1'b1;
    tick();
    bus_a.start_strb = 1'b0;
    checks++;
    if (bus_a.cntr !== 5'd1 || bus_a.strb !== 1'b0) begin
      errors++; $display("FAIL seq16_start: cntr=%0d strb=%0b required 1/0", bus_a.cntr, bus_a.strb);
    end
    strobes = 0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (bus_a.strb === 1'b1) strobes++;
      checks++;
      if (int'(bus_a.cntr) !== (j < 16 ? j + 1 : 0) || bus_a.strb !== (j == 16)) begin
        errors++;
        $display("FAIL seq16_run: edge k+%0d cntr=%0d strb=%0b required %0d/%0b",
                 j, bus_a.cntr, bus_a.strb, (j < 16 ? j + 1 : 0), (j == 16));
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++; $display("FAIL seq16_strobe_count: got %0d required 1", strobes);
    end
  endtask

  // Each fed-back start consumes the strobe-high edge and loads 1, so strobes repeat every max+1 edges
  task automatic test_chained();
    int edge_no;
    int starts;
    bit fed;
    int strobe_at[$];
    do_reset();
    bus_b.enable = 1'b1;
    bus_b.start_strb = 1'b1;
    tick();
    starts = 1;
    edge_no = 0;
    for (int c = 0; c < 260; c++) begin
      fed = (bus_b.strb === 1'b1) && (starts < 3);
      bus_b.start_strb = fed;
      if (fed) starts++;
      tick();
      edge_no++;
      if (bus_b.strb === 1'b1) strobe_at.push_back(edge_no);
      if (fed) begin
        checks++;
        if (bus_b.cntr !== 8'd1) begin
          errors++; $display("FAIL chain_restart: cntr=%0d required 1 after feedback start", bus_b.cntr);
        end
      end
    end
    bus_b.start_strb = 1'b0;
    checks++;
    if (strobe_at.size() != 3) begin
      errors++; $display("FAIL chain_count: got %0d strobes required 3", strobe_at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (strobe_at[i] != 64 + i * 65) begin
          errors++; $display("FAIL chain_position: strobe %0d at edge %0d required %0d", i, strobe_at[i], 64 + i * 65);
        end
      end
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    run_b_to(30);
    bus_b.start_strb = 1'b1;
    tick();
    bus_b.start_strb = 1'b0;
    checks++;
    if (bus_b.cntr !== 8'd1) begin
      errors++; $display("FAIL retrig_load: cntr=%0d required 1", bus_b.cntr);
    end
    for (int j = 1; j <= 80; j++) begin
      tick();
      checks++;
      if (int'(bus_b.cntr) !== (j < 64 ? j + 1 : 0) || bus_b.strb !== (j == 64)) begin
        errors++;
        $display("FAIL retrig_run: edge s2+%0d cntr=%0d strb=%0b required %0d/%0b",
                 j, bus_b.cntr, bus_b.strb, (j < 64 ? j + 1 : 0), (j == 64));
      end
    end
  endtask

  task automatic test_stall();
    int drop_at;
    int ens;
    do_reset();
    drop_at = $urandom_range(5, 40);
    bus_b.enable = 1'b1;
    bus_b.start_strb = 1'b1;
    tick();
    bus_b.start_strb = 1'b0;
    ens = 0;
    for (int j = 1; j <= 90; j++) begin
      bus_b.enable = !(j > drop_at && j <= drop_at + 5);
      tick();
      if (bus_b.enable) ens++;
      checks++;
      if (int'(bus_b.cntr) !== (j < 69 ? ens + 1 : 0) || bus_b.strb !== (j == 69)) begin
        errors++;
        $display("FAIL stall_run: edge s+%0d cntr=%0d strb=%0b required %0d/%0b",
                 j, bus_b.cntr, bus_b.strb, (j < 69 ? ens + 1 : 0), (j == 69));
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    run_b_to(40);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (bus_b.cntr !== 8'd0 || bus_b.strb !== 1'b0) begin
      errors++; $display("FAIL abort_reset: cntr=%0d strb=%0b required 0/0", bus_b.cntr, bus_b.strb);
    end
    for (int j = 0; j < 80; j++) begin
      tick();
      checks++;
      if (bus_b.cntr !== 8'd0 || bus_b.strb !== 1'b0) begin
        errors++; $display("FAIL abort_quiet: cycle %0d cntr=%0d strb=%0b required 0/0", j, bus_b.cntr, bus_b.strb);
      end
    end
  endtask

`ifdef SDC_CNTR_CLR_EN
  task automatic test_clr();
    do_reset();
    run_b_to(40);
    bus_b.clr = 1'b1;
    tick();
    bus_b.clr = 1'b0;
    checks++;
    if (bus_b.cntr !== 8'd0 || bus_b.strb !== 1'b0) begin
      errors++; $display("FAIL clr_abort: cntr=%0d strb=%0b required 0/0", bus_b.cntr, bus_b.strb);
    end
    run_b_to(64);
    bus_b.clr = 1'b1;
    tick();
    bus_b.clr = 1'b0;
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (bus_b.cntr !== 8'd0 || bus_b.strb !== 1'b0) begin
        errors++; $display("FAIL clr_terminal: cycle %0d cntr=%0d strb=%0b required 0/0", j, bus_b.cntr, bus_b.strb);
      end
      tick();
    end
  endtask
`endif

  // Random enables/starts on the event and 64-bit sequence counters against arithmetic models
  task automatic test_random();
    int  n_en;
    bit  active;
    int  bits_done;
    bit  en_e, en_b, st_b;
    bit  exp_strb_e, exp_strb_b;
    do_reset();
    n_en = 0;
    active = 1'b0;
    bits_done = 0;
    for (int c = 0; c < 1500; c++) begin
      en_e = ($urandom_range(0, 9) < 7);
      en_b = ($urandom_range(0, 9) < 8);
      st_b = ($urandom_range(0, 99) < 2);
      bus_e.enable = en_e;
      bus_e.start_strb = 1'($urandom_range(0, 1));
      bus_b.enable = en_b;
      bus_b.start_strb = st_b;
      tick();
      if (en_e) n_en++;
      exp_strb_e = en_e && (n_en % 64 == 0);
      exp_strb_b = active && en_b && (bits_done == 64);
      if (st_b) begin
        active = 1'b1;
        bits_done = 1;
      end else if (active && en_b) begin
        if (bits_done == 64) begin
          active = 1'b0;
          bits_done = 0;
        end else begin
          bits_done++;
        end
      end
      checks++;
      if (int'(bus_e.cntr) !== n_en % 64 || bus_e.strb !== exp_strb_e) begin
        errors++;
        $display("FAIL rand_event: cycle %0d cntr=%0d strb=%0b required %0d/%0b",
                 c, bus_e.cntr, bus_e.strb, n_en % 64, exp_strb_e);
      end
      checks++;
      if (int'(bus_b.cntr) !== bits_done || bus_b.strb !== exp_strb_b) begin
        errors++;
        $display("FAIL rand_seq: cycle %0d cntr=%0d strb=%0b required %0d/%0b",
                 c, bus_b.cntr, bus_b.strb, bits_done, exp_strb_b);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_event_wrap();
    test_seq_length();
    test_chained();
    test_retrigger();
    test_stall();
    test_abort();
`ifdef SDC_CNTR_CLR_EN
    test_clr();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
